// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART link controller.
// The optional loopback compare in uart_link_ctrl is enabled with LOOPBACK_CHECK_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_LOAD    = 3'd1,
        TX_SEND    = 3'd2,
        TX_WAIT_HI = 3'd3,
        TX_WAIT_LO = 3'd4,
        TX_GAP     = 3'd5
    } tx_state_t;

    localparam int IDX_W = 2;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = 4'hF;

    // Byte 0 is the most significant byte of the message word.
    function automatic logic [7:0] msg_byte(input logic [31:0] msg, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = msg[31:24];
            2'd1:    b = msg[23:16];
            2'd2:    b = msg[15:8];
            default: b = msg[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_assembler.sv
// Assembles received bytes into a 32-bit display word, updated atomically
// once all four bytes of a frame arrive; line errors restart the frame.
module uart_rx_assembler
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_perror_i,
    input  logic             rx_ferror_i,
    output logic [31:0]      disp_word_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [3:0][7:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic [31:0]       disp_q, disp_d;
    logic              frame_q, frame_d;
    logic [CNT_W-1:0]  err_q, err_d;

    always_comb begin
        shadow_d = shadow_q;
        rx_idx_d = rx_idx_q;
        disp_d   = disp_q;
        frame_d  = 1'b0;
        err_d    = err_q;
        if (rx_valid_i) begin
            if (rx_perror_i || rx_ferror_i) begin
                rx_idx_d = '0;
                err_d    = sat_inc(err_q);
            end else begin
                shadow_d[rx_idx_q] = rx_data_i;
                if (rx_idx_q == 2'd3) begin
                    rx_idx_d = '0;
                    disp_d   = {shadow_q[0], shadow_q[1], shadow_q[2], rx_data_i};
                    frame_d  = 1'b1;
                end else begin
                    rx_idx_d = rx_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            rx_idx_q <= '0;
            disp_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            rx_idx_q <= rx_idx_d;
            disp_q   <= disp_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign disp_word_o  = disp_q;
    assign frame_done_o = frame_q;
    assign err_cnt_o    = err_q;

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: 4-byte message transmit sequencer plus receive assembler.
// Define LOOPBACK_CHECK_EN to compare received frames against the last sent message.
module uart_link_ctrl
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES = 1000,
    parameter int GAP_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] tx_msg,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_perror,
    input  logic        rx_ferror,
    output logic [31:0] disp_word,
    output logic        frame_done,
    output logic [3:0]  err_cnt,
    output logic [3:0]  mismatch_cnt,
    output logic [2:0]  tx_state_dbg
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Transmitter handshake: one tx_wr pulse per byte, issued only while
    // tx_busy is low; the byte is accepted once tx_busy rises, and the
    // transmitter is free again when tx_busy falls.
    tx_state_t         state_q, state_d;
    logic [31:0]       msg_q, msg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              wr_q, wr_d;
    logic [7:0]        data_q, data_d;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        case (state_q)
            TX_IDLE: begin
                if (enable) state_d = TX_LOAD;
            end
            TX_LOAD: begin
                msg_d   = tx_msg;
                idx_d   = '0;
                state_d = TX_SEND;
                if (!tx_busy) begin
                    wr_d   = 1'b1;
                    data_d = tx_msg[31:24];
                end
            end
            TX_SEND: begin
                if (wr_q) begin
                    state_d = TX_WAIT_HI;
                end else if (!tx_busy) begin
                    wr_d   = 1'b1;
                    data_d = msg_byte(msg_q, idx_q);
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy) state_d = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == 2'd3) begin
                        state_d = TX_GAP;
                        gap_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = TX_SEND;
                        wr_d    = 1'b1;
                        data_d  = msg_byte(msg_q, idx_q + 1'b1);
                    end
                end
            end
            TX_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = enable ? TX_LOAD : TX_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            msg_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign tx_wr        = wr_q;
    assign tx_data      = data_q;
    assign tx_state_dbg = state_q;

    uart_rx_assembler u_rx (
        .clk          (clk),
        .rst_n        (reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_perror_i  (rx_perror),
        .rx_ferror_i  (rx_ferror),
        .disp_word_o  (disp_word),
        .frame_done_o (frame_done),
        .err_cnt_o    (err_cnt)
    );

`ifdef LOOPBACK_CHECK_EN
    logic [31:0]      sent_q;
    logic             sent_vld_q;
    logic [CNT_W-1:0] mis_q;
    logic             msg_done;

    // A message counts as sent once the last byte's busy phase has ended.
    assign msg_done = (state_q == TX_WAIT_LO) && !tx_busy && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q     <= '0;
            sent_vld_q <= 1'b0;
            mis_q      <= '0;
        end else begin
            if (msg_done) begin
                sent_q     <= msg_q;
                sent_vld_q <= 1'b1;
            end
            if (frame_done && sent_vld_q && (disp_word != sent_q)) begin
                mis_q <= sat_inc(mis_q);
            end
        end
    end

    assign mismatch_cnt = mis_q;
`else
    assign mismatch_cnt = 4'h0;
`endif

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: transmitter model, rx driver, tx/rx monitors.
module tb_uart_link_ctrl;
    import uart_pkg::*;

    localparam int GAP   = 20;
    localparam int BUSY  = 10;
`ifdef LOOPBACK_CHECK_EN
    localparam logic [3:0] EXP_MIS = 4'd1;
`else
    localparam logic [3:0] EXP_MIS = 4'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] tx_msg;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_perror;
    logic        rx_ferror;
    logic [31:0] disp_word;
    logic        frame_done;
    logic [3:0]  err_cnt;
    logic [3:0]  mismatch_cnt;
    logic [2:0]  tx_state_dbg;

    uart_link_ctrl #(.GAP_CYCLES(GAP), .GAP_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .tx_msg       (tx_msg),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_perror    (rx_perror),
        .rx_ferror    (rx_ferror),
        .disp_word    (disp_word),
        .frame_done   (frame_done),
        .err_cnt      (err_cnt),
        .mismatch_cnt (mismatch_cnt),
        .tx_state_dbg (tx_state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_tx_q[$];
    logic [31:0] exp_disp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transmitter model + tx monitor ----------------
    int wr_count     = 0;
    int first_wr_cyc = 0;
    int fall_cyc     = 0;
    int busy_cnt     = 0;
    logic prev_wr    = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (tx_wr) begin
                check("wr_pulse_width", {31'd0, prev_wr}, 32'd0);
                check("wr_while_busy", {31'd0, tx_busy}, 32'd0);
                if (wr_count == 0) first_wr_cyc = cyc;
                if (wr_count == 4 || wr_count == 8)
                    check("msg_gap_cycles", cyc - fall_cyc, GAP + 2);
                else if (wr_count % 4 != 0)
                    check("byte_spacing_ge1", {31'd0, (cyc - fall_cyc) >= 1}, 32'd1);
                if (exp_tx_q.size() == 0) begin
                    check("unexpected_tx_wr", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
                end
                wr_count++;
                tx_busy  = 1'b1;
                busy_cnt = BUSY;
            end
            prev_wr = tx_wr;
        end
    end

    // ---------------- rx monitor ----------------
    int frame_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) begin
                frame_cnt++;
                if (exp_disp_q.size() == 0)
                    check("unexpected_frame_done", disp_word, 32'hFFFF_FFFF);
                else
                    check("disp_word", disp_word, exp_disp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_rx(input logic [7:0] d, input logic pe, input logic fe);
        rx_valid  = 1'b1;
        rx_data   = d;
        rx_perror = pe;
        rx_ferror = fe;
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_rx(w[31:24], 1'b0, 1'b0);
        send_rx(w[23:16], 1'b0, 1'b0);
        send_rx(w[15:8],  1'b0, 1'b0);
        send_rx(w[7:0],   1'b0, 1'b0);
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (wr_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_wr_count", wr_count, n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (tx_state_dbg != TX_IDLE && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_state", {29'd0, tx_state_dbg}, {29'd0, TX_IDLE});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_wr"}, {31'd0, tx_wr}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_disp_word"}, disp_word, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_err_cnt"}, {28'd0, err_cnt}, 32'd0);
        check({tag, "_mismatch_cnt"}, {28'd0, mismatch_cnt}, 32'd0);
        check({tag, "_state"}, {29'd0, tx_state_dbg}, {29'd0, TX_IDLE});
    endtask

    // ---------------- main stimulus ----------------
    int c0;

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        tx_msg    = 32'h0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Receive: clean frame, then error-interrupted frame, then saturation.
        exp_disp_q.push_back(32'h1234_5678);
        send_frame(32'h1234_5678);
        check("frame_cnt_1", frame_cnt, 1);
        check("disp_after_frame1", disp_word, 32'h1234_5678);

        exp_disp_q.push_back(32'h9ABC_DEF0);
        send_rx(8'h12, 1'b0, 1'b0);
        send_rx(8'h34, 1'b0, 1'b0);
        send_rx(8'h56, 1'b0, 1'b1);
        check("err_cnt_after_ferror", {28'd0, err_cnt}, 32'd1);
        check("disp_unchanged_on_err", disp_word, 32'h1234_5678);
        send_frame(32'h9ABC_DEF0);
        check("frame_cnt_2", frame_cnt, 2);
        check("err_cnt_still_1", {28'd0, err_cnt}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            send_rx(8'($urandom_range(0, 255)), (i % 3) != 1, (i % 3) != 0);
        end
        check("err_cnt_saturated", {28'd0, err_cnt}, 32'd15);
        check("frame_cnt_no_error_frames", frame_cnt, 2);
        check("disp_after_errors", disp_word, 32'h9ABC_DEF0);
        check("mismatch_before_any_tx", {28'd0, mismatch_cnt}, 32'd0);

        // Transmit: A1B2C3D4 twice, then 11223344 picked up after mid-message change.
        foreach (exp_tx_q[i]) exp_tx_q.delete(i);
        exp_tx_q.push_back(8'hA1); exp_tx_q.push_back(8'hB2);
        exp_tx_q.push_back(8'hC3); exp_tx_q.push_back(8'hD4);
        exp_tx_q.push_back(8'hA1); exp_tx_q.push_back(8'hB2);
        exp_tx_q.push_back(8'hC3); exp_tx_q.push_back(8'hD4);
        exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
        exp_tx_q.push_back(8'h33); exp_tx_q.push_back(8'h44);
        tx_msg = 32'hA1B2_C3D4;
        c0     = cyc;
        enable = 1'b1;
        wait_wr(1, 20);
        check("first_wr_latency", first_wr_cyc - c0, 2);
        wait_wr(7, 400);
        tx_msg = 32'h1122_3344;
        wait_wr(10, 400);
        enable = 1'b0;
        wait_wr(12, 200);
        wait_idle(200);
        repeat (60) @(negedge clk);
        check("no_wr_after_disable", wr_count, 12);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("tx_data_holds", {24'd0, tx_data}, 32'h44);

        // Loopback: corrupted copy of the last message, then the exact copy.
        exp_disp_q.push_back(32'h1122_3345);
        send_frame(32'h1122_3345);
        check("mismatch_after_corrupt", {28'd0, mismatch_cnt}, {28'd0, EXP_MIS});
        exp_disp_q.push_back(32'h1122_3344);
        send_frame(32'h1122_3344);
        check("mismatch_after_clean", {28'd0, mismatch_cnt}, {28'd0, EXP_MIS});
        check("frame_cnt_4", frame_cnt, 4);

        // Asynchronous reset in the middle of a byte.
        exp_tx_q.push_back(8'h11);
        enable = 1'b1;
        wait_wr(13, 40);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("no_wr_after_reset", wr_count, 13);
        check("state_idle_after_reset", {29'd0, tx_state_dbg}, {29'd0, TX_IDLE});
        check("tx_queue_empty", exp_tx_q.size(), 0);
        check("disp_queue_empty", exp_disp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
